// File: rtl/gate_tt_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_tt_checker: sweeps all 2^N input vectors into two implementations of   |
// | one gate, compares their responses (and optionally a truth table).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_tt_checker #(
  parameter int unsigned       N      = 2,
  parameter int unsigned       SETTLE = 1,
  parameter bit                USE_TT = 1'b0,
  parameter logic [(2**N)-1:0] TT     = 4'b1110
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         resp_a,
  input  logic         resp_b,
  output logic [N-1:0] vec_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail_vec
);

  localparam int unsigned      CNT_W      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] C_SETTLE   = CNT_W'(SETTLE);
  localparam logic [N-1:0]     C_LAST_VEC = {N{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_fail;
  logic [N:0]       err_d;

  generate
    if (USE_TT) begin : g_tt_check
      logic w_tt_bit;
      assign w_tt_bit = TT[vec_out];
      assign w_fail   = (resp_a != resp_b) || (resp_a != w_tt_bit);
    end else begin : g_pair_only
      assign w_fail = (resp_a != resp_b);
    end
  endgenerate

  // Count including the vector being compared now, so pass covers the last one.
  assign err_d = err_count + {{N{1'b0}}, w_fail};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q        <= ST_DRIVE;
            cnt_q          <= '0;
            vec_out        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q != C_SETTLE) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (w_fail) begin
              err_count <= err_d;
              if (!fail_valid) begin
                first_fail_vec <= vec_out;
                fail_valid     <= 1'b1;
              end
            end
            if (vec_out == C_LAST_VEC) begin
              state_q <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_d == '0);
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gate_tt_checker: directed sweeps against a cycle-level reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gate_tt_checker;

  localparam logic [3:0] TT_C = 4'b1110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       ra0, rb0, ra1, rb1;
  logic [1:0] vec0, vec1, ffv0, ffv1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [2:0] err0, err1;
  int         mode = 0;
  int         errors = 0;
  int         checks = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  gate_tt_checker #(.N(2), .SETTLE(1), .USE_TT(1'b1), .TT(TT_C)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .resp_a(ra0), .resp_b(rb0),
    .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail_vec(ffv0)
  );

  gate_tt_checker #(.N(2), .SETTLE(0), .USE_TT(1'b0), .TT(TT_C)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .resp_a(ra1), .resp_b(rb1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  // Mode 0: both OR; mode 1: A=OR, B stuck at 0; mode 2: both AND.
  function automatic logic fa(int m, logic [1:0] v);
    return (m == 2) ? (v[1] & v[0]) : (v[1] | v[0]);
  endfunction

  function automatic logic fb(int m, logic [1:0] v);
    if (m == 1) return 1'b0;
    return (m == 2) ? (v[1] & v[0]) : (v[1] | v[0]);
  endfunction

  always_comb begin
    ra0 = fa(mode, vec0);
    rb0 = fb(mode, vec0);
    ra1 = fa(mode, vec1);
    rb1 = fb(mode, vec1);
  end

  function automatic bit vfail(int m, bit use_tt, int v);
    logic [1:0] vv = 2'(v);
    logic [3:0] t = TT_C;
    logic a = fa(m, vv);
    logic b = fb(m, vv);
    return (a != b) || (use_tt && (a != t[v]));
  endfunction

  function automatic int nfail(int m, bit use_tt, int upto);
    int n = 0;
    for (int v = 0; v < upto; v++) if (vfail(m, use_tt, v)) n++;
    return n;
  endfunction

  function automatic int ffail(int m, bit use_tt, int upto);
    for (int v = 0; v < upto; v++) if (vfail(m, use_tt, v)) return v;
    return 0;
  endfunction

  // Reference model: sweep phase and cycle count per checker instance.
  int m_st[2]   = '{0, 0};
  int m_cyc[2]  = '{0, 0};
  int m_mode[2] = '{0, 0};
  int hold[2]   = '{2, 1};
  bit use_tt[2] = '{1'b1, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic s;
      s = (d == 0) ? start0 : start1;
      if (reset) begin
        m_st[d]  = 0;
        m_cyc[d] = 0;
      end else if (m_st[d] == 1) begin
        m_cyc[d]++;
        if (m_cyc[d] == 4 * hold[d]) m_st[d] = 2;
      end else if (s) begin
        m_st[d]   = 1;
        m_cyc[d]  = 0;
        m_mode[d] = mode;
      end
    end
  end

  // Packing: {vec[1:0], busy, done, pass, err[2:0], fail_valid, first_fail[1:0]}
  function automatic logic [10:0] expect_pk(int d);
    int k, n;
    if (m_st[d] == 1) begin
      k = m_cyc[d] / hold[d];
      n = nfail(m_mode[d], use_tt[d], k);
      return {2'(k), 1'b1, 1'b0, 1'b0, 3'(n), (n > 0), 2'(ffail(m_mode[d], use_tt[d], k))};
    end else if (m_st[d] == 2) begin
      n = nfail(m_mode[d], use_tt[d], 4);
      return {2'b11, 1'b0, 1'b1, (n == 0), 3'(n), (n > 0), 2'(ffail(m_mode[d], use_tt[d], 4))};
    end
    return 11'd0;
  endfunction

  function automatic logic [10:0] got_pk(int d);
    if (d == 0) return {vec0, busy0, done0, pass0, err0, fv0, ffv0};
    return {vec1, busy1, done1, pass1, err1, fv1, ffv1};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [10:0] e, g;
        e = expect_pk(d);
        g = got_pk(d);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL model dut%0d t=%0t: got %b, expected %b", d, $time, g, e);
        end
      end
    end
  end

  task automatic lchk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Pulses start for one cycle (optionally again at busy-cycle extra_at) and
  // follows the sweep until done, recording busy length and vector sequence.
  task automatic sweep(input int d, input int extra_at, output int nbusy,
                       output logic [15:0] seq, output logic [10:0] first_pk);
    bit fin = 1'b0;
    nbusy = 0;
    seq = '0;
    first_pk = '0;
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 60 && !fin; i++) begin
      logic [10:0] g;
      g = got_pk(d);
      if (i == 0) first_pk = g;
      if (g[8]) begin
        nbusy++;
        seq = {seq[13:0], g[10:9]};
      end
      if (g[7]) fin = 1'b1;
      if (d == 0) start0 = (i == extra_at); else start1 = (i == extra_at);
      if (!fin) @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout dut%0d: got done=0, expected done=1", d);
    end
  endtask

  int          nb;
  logic [15:0] sq;
  logic [10:0] fp;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    lchk("reset_state", {5'd0, got_pk(0)}, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    mode = 0;
    sweep(0, -1, nb, sq, fp);
    lchk("or_busy_len", 16'(nb), 16'd8);
    lchk("or_vec_seq", sq, 16'h05AF);
    lchk("or_result", {5'd0, got_pk(0)}, {5'd0, 11'b11011000000});

    mode = 1;
    sweep(0, -1, nb, sq, fp);
    lchk("stuckb_result", {5'd0, got_pk(0)}, {5'd0, 11'b11010011101});

    mode = 2;
    sweep(0, -1, nb, sq, fp);
    lchk("and_result", {5'd0, got_pk(0)}, {5'd0, 11'b11010010101});

    mode = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 20 && vec0 != 2'b10; i++) @(negedge clk);
    lchk("pre_reset_vec", {14'd0, vec0}, 16'h0002);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lchk("mid_reset_state", {5'd0, got_pk(0)}, 16'd0);
    sweep(0, -1, nb, sq, fp);
    lchk("post_reset_busy_len", 16'(nb), 16'd8);
    lchk("post_reset_pass", {15'd0, pass0}, 16'd1);

    mode = 1;
    sweep(0, 3, nb, sq, fp);
    lchk("ignored_start_busy_len", 16'(nb), 16'd8);
    lchk("ignored_start_result", {5'd0, got_pk(0)}, {5'd0, 11'b11010011101});
    sweep(0, -1, nb, sq, fp);
    lchk("restart_first_cycle", {5'd0, fp}, {5'd0, 11'b00100000000});
    lchk("restart_busy_len", 16'(nb), 16'd8);

    mode = 0;
    sweep(1, -1, nb, sq, fp);
    lchk("settle0_busy_len", 16'(nb), 16'd4);
    lchk("settle0_vec_seq", sq, 16'h001B);
    lchk("settle0_result", {5'd0, got_pk(1)}, {5'd0, 11'b11011000000});

    start1 = 1'b1;
    repeat (12) @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 10 && !done1; i++) @(negedge clk);
    lchk("back_to_back_done", {15'd0, done1}, 16'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
